// File: rtl/cpu_mem_responder_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_responder_if
// Purpose : Memory-bus bundle between the multicycle CPU (initiator) and the
//           memory responder (target).
// Signals (prefixes are from the responder's point of view):
//   i_addr        AW  byte address, bit0 ignored
//   i_rd          1   read request
//   i_wr          1   write request
//   i_wdata       16  write data
//   o_waitrequest 1   high = request not accepted this cycle
//   o_rdata       16  registered read data
//   o_rvalid      1   one-cycle pulse after an accepted read
// Modports : master (CPU side), slave (responder side)
// ----------------------------------------------------------------------------
interface cpu_mem_responder_if #(
    parameter int AW = 16
);
    logic [AW-1:0] i_addr;
    logic          i_rd;
    logic          i_wr;
    logic [15:0]   i_wdata;
    logic          o_waitrequest;
    logic [15:0]   o_rdata;
    logic          o_rvalid;

    modport master (
        output i_addr, i_rd, i_wr, i_wdata,
        input  o_waitrequest, o_rdata, o_rvalid
    );

    modport slave (
        input  i_addr, i_rd, i_wr, i_wdata,
        output o_waitrequest, o_rdata, o_rvalid
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// ----------------------------------------------------------------------------
// cpu_mem_responder
// Purpose : Bus target for the multicycle CPU. Holds an inferred 16-bit word
//           RAM, a small MMIO bank (GPIO, free-running cycle counter, status)
//           and a wait-state FSM that stretches every access to
//           WAIT_CYCLES+1 cycles.
// Ports   :
//   i_clk    in   clock, all logic on posedge
//   i_reset  in   synchronous active-low reset
//   io_bus   slave modport of cpu_mem_responder_if (addr/rd/wr/wdata in,
//            waitrequest/rdata/rvalid out)
//   o_gpio   out  16-bit GPIO output register
//   o_err    out  sticky flag, set when an unmapped access is accepted
// Memory map (byte addresses):
//   0 .. 2*RAM_WORDS-1  RAM
//   MMIO_BASE+0         GPIO   (RW)
//   MMIO_BASE+2         CYCLE  (RO, any write clears it)
//   MMIO_BASE+4         STATUS (RO {15'b0,o_err}, any write clears o_err)
// Configuration macro: CPU_MEM_CYCLE_COUNTER_EN
//   defined   -> CYCLE register present
//   undefined -> counter removed, MMIO_BASE+2 decodes as unmapped
// ----------------------------------------------------------------------------
module cpu_mem_responder #(
    parameter int            AW          = 16,
    parameter int            RAM_WORDS   = 4096,
    parameter logic [AW-1:0] MMIO_BASE   = 16'hFF00,
    parameter int            WAIT_CYCLES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    cpu_mem_responder_if.slave    io_bus,
    output logic [15:0]           o_gpio,
    output logic                  o_err
);

    localparam int              LP_RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [AW:0]     LP_RAM_LIMIT = (AW+1)'(2 * RAM_WORDS);
    localparam logic [AW-2:0]   LP_GPIO_W    = MMIO_BASE[AW-1:1];
    localparam logic [AW-2:0]   LP_CYCLE_W   = LP_GPIO_W + (AW-1)'(1);
    localparam logic [AW-2:0]   LP_STATUS_W  = LP_GPIO_W + (AW-1)'(2);
    localparam logic [3:0]      LP_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cntNext;
    logic                w_waitrequest;
    logic                w_req;
    logic                w_accept;
    logic                w_wrAccept;
    logic                w_rdAccept;
    logic [AW-2:0]       w_wordAddr;
    logic [LP_RAM_AW-1:0] w_ramIdx;
    logic                w_isRam;
    logic                w_isGpio;
    logic                w_isCycle;
    logic                w_isStatus;
    logic                w_isUnmapped;
    logic [15:0]         w_mmioRdata;
    logic [15:0]         r_rdata;
    logic                r_rvalid;
    logic [15:0]         r_gpio;
    logic                r_err;
    logic [15:0]         r_ram [RAM_WORDS];
    logic                w_unusedAddr0;
`ifdef CPU_MEM_CYCLE_COUNTER_EN
    logic [15:0]         r_cycle;
`endif

    // Word accesses only, so the byte-select bit carries no information.
    assign w_unusedAddr0 = io_bus.i_addr[0];

    // Address decode on the word address; RAM limit is compared on the
    // full byte address so any RAM_WORDS value maps cleanly.
    assign w_wordAddr = io_bus.i_addr[AW-1:1];
    assign w_ramIdx   = io_bus.i_addr[LP_RAM_AW:1];
    assign w_isRam    = ({1'b0, w_wordAddr, 1'b0} < LP_RAM_LIMIT);
    assign w_isGpio   = (w_wordAddr == LP_GPIO_W);
    assign w_isStatus = (w_wordAddr == LP_STATUS_W);
`ifdef CPU_MEM_CYCLE_COUNTER_EN
    assign w_isCycle  = (w_wordAddr == LP_CYCLE_W);
`else
    assign w_isCycle  = 1'b0;
`endif
    assign w_isUnmapped = !(w_isRam || w_isGpio || w_isCycle || w_isStatus);

    // A request is accepted only outside reset and when waitrequest is low;
    // rd together with wr is a write only.
    assign w_req      = io_bus.i_rd || io_bus.i_wr;
    assign w_accept   = i_reset && w_req && !w_waitrequest;
    assign w_wrAccept = w_accept && io_bus.i_wr;
    assign w_rdAccept = w_accept && io_bus.i_rd && !io_bus.i_wr;

    // Wait-state FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state and waitrequest. A request dropped during S_WAIT sends the
    // FSM back to idle without anything being accepted.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_waitrequest = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && (WAIT_CYCLES != 0)) begin
                    w_waitrequest = 1'b1;
                    w_cntNext     = LP_WAIT_LOAD;
                    w_stateNext   = S_WAIT;
                end
            end
            S_WAIT: begin
                w_waitrequest = (r_cnt != 4'd0);
                if (!w_req) begin
                    w_stateNext = S_IDLE;
                    w_cntNext   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_cntNext = r_cnt - 4'd1;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_cntNext   = 4'd0;
            end
        endcase
    end

    // MMIO read mux; unmapped addresses fall through to zero.
    always_comb begin
        w_mmioRdata = 16'h0000;
        if (w_isGpio) begin
            w_mmioRdata = r_gpio;
`ifdef CPU_MEM_CYCLE_COUNTER_EN
        end else if (w_isCycle) begin
            w_mmioRdata = r_cycle;
`endif
        end else if (w_isStatus) begin
            w_mmioRdata = {15'b0, r_err};
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_wrAccept && w_isRam) begin
            r_ram[w_ramIdx] <= io_bus.i_wdata;
        end
    end

    // Registered read data and its one-cycle valid strobe; data holds
    // between reads.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rdata  <= 16'h0000;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rdAccept;
            if (w_rdAccept) begin
                r_rdata <= w_isRam ? r_ram[w_ramIdx] : w_mmioRdata;
            end
        end
    end

    // GPIO output register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_gpio <= 16'h0000;
        end else if (w_wrAccept && w_isGpio) begin
            r_gpio <= io_bus.i_wdata;
        end
    end

    // Sticky error flag: set by any accepted unmapped access, cleared by a
    // write to STATUS.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_err <= 1'b0;
        end else if (w_accept && w_isUnmapped) begin
            r_err <= 1'b1;
        end else if (w_wrAccept && w_isStatus) begin
            r_err <= 1'b0;
        end
    end

`ifdef CPU_MEM_CYCLE_COUNTER_EN
    // Free-running cycle counter; a write lands it on zero rather than one.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cycle <= 16'h0000;
        end else if (w_wrAccept && w_isCycle) begin
            r_cycle <= 16'h0000;
        end else begin
            r_cycle <= r_cycle + 16'd1;
        end
    end
`endif

    assign io_bus.o_waitrequest = w_waitrequest;
    assign io_bus.o_rdata       = r_rdata;
    assign io_bus.o_rvalid      = r_rvalid;
    assign o_gpio               = r_gpio;
    assign o_err                = r_err;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_cpu_mem_responder
// Purpose : Directed self-checking bench. dut0 runs with no wait states,
//           dut3 with three wait states and its own reset so accesses can be
//           aborted mid-wait.
// ----------------------------------------------------------------------------
module tb_cpu_mem_responder;

    logic        clock;
    logic        resetN0;
    logic        resetN3;
    logic [15:0] gpio0;
    logic [15:0] gpio3;
    logic        err0;
    logic        err3;
    int          passCount;
    int          checkCount;

    cpu_mem_responder_if #(.AW(16)) bus0 ();
    cpu_mem_responder_if #(.AW(16)) bus3 ();

    cpu_mem_responder #(
        .AW(16), .RAM_WORDS(4096), .MMIO_BASE(16'hFF00), .WAIT_CYCLES(0)
    ) dut0 (
        .i_clk(clock), .i_reset(resetN0), .io_bus(bus0), .o_gpio(gpio0), .o_err(err0)
    );

    cpu_mem_responder #(
        .AW(16), .RAM_WORDS(4096), .MMIO_BASE(16'hFF00), .WAIT_CYCLES(3)
    ) dut3 (
        .i_clk(clock), .i_reset(resetN3), .io_bus(bus3), .o_gpio(gpio3), .o_err(err3)
    );

    // 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one request onto the selected bus (0 = dut0, otherwise dut3).
    task automatic applyStimulus(input int d, input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        if (d == 0) begin
            bus0.i_rd = rd; bus0.i_wr = wr; bus0.i_addr = addr; bus0.i_wdata = wdata;
        end else begin
            bus3.i_rd = rd; bus3.i_wr = wr; bus3.i_addr = addr; bus3.i_wdata = wdata;
        end
    endtask

    // One comparison with pass/total bookkeeping.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    function automatic logic getWait(input int d);
        return (d == 0) ? bus0.o_waitrequest : bus3.o_waitrequest;
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Full bounded access: hold the request until waitrequest drops, let the
    // edge accept it, then release the bus. Returns 1 ns after the accepting
    // edge, so registered results are already visible.
    task automatic doAccess(input int d, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [15:0] wdata);
        int n;
        n = 0;
        applyStimulus(d, rd, wr, addr, wdata);
        @(negedge clock);
        while (getWait(d) && n < 32) begin
            @(negedge clock);
            n++;
        end
        checkOutput("acceptBeforeTimeout", {15'b0, (n < 32)}, 16'd1);
        stepCycle();
        applyStimulus(d, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        resetN0    = 1'b0;
        resetN3    = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset held for two cycles, then released.
        repeat (2) stepCycle();
        checkOutput("rstGpio", gpio0, 16'h0000);
        checkOutput("rstRvalid", {15'b0, bus0.o_rvalid}, 16'd0);
        checkOutput("rstErr", {15'b0, err0}, 16'd0);
        checkOutput("rstRdata", bus0.o_rdata, 16'h0000);
        resetN0 = 1'b1;
        resetN3 = 1'b1;
        stepCycle();
        checkOutput("rstWait0", {15'b0, bus0.o_waitrequest}, 16'd0);
        checkOutput("rstWait3", {15'b0, bus3.o_waitrequest}, 16'd0);
        checkOutput("rstErr3", {15'b0, err3}, 16'd0);

        // Zero-wait write then back-to-back read of the same word.
        applyStimulus(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        @(negedge clock);
        checkOutput("wrNoWait", {15'b0, bus0.o_waitrequest}, 16'd0);
        stepCycle();
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        @(negedge clock);
        checkOutput("rdNoWait", {15'b0, bus0.o_waitrequest}, 16'd0);
        checkOutput("rvalidBeforeRead", {15'b0, bus0.o_rvalid}, 16'd0);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("rvalidPulse", {15'b0, bus0.o_rvalid}, 16'd1);
        checkOutput("rdataBeef", bus0.o_rdata, 16'hBEEF);
        stepCycle();
        checkOutput("rvalidOneCycle", {15'b0, bus0.o_rvalid}, 16'd0);
        checkOutput("rdataHold", bus0.o_rdata, 16'hBEEF);

        // Byte bit 0 is ignored.
        doAccess(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
        checkOutput("rdOddAddr", bus0.o_rdata, 16'hBEEF);

        // Top RAM word.
        doAccess(0, 1'b0, 1'b1, 16'h1FFE, 16'hC0DE);
        doAccess(0, 1'b1, 1'b0, 16'h1FFE, 16'h0000);
        checkOutput("rdRamTop", bus0.o_rdata, 16'hC0DE);
        checkOutput("ramTopNoErr", {15'b0, err0}, 16'd0);

        // rd and wr together: a GPIO write, no read strobe, rdata untouched.
        doAccess(0, 1'b1, 1'b1, 16'hFF00, 16'h1234);
        checkOutput("rdWrGpio", gpio0, 16'h1234);
        checkOutput("rdWrNoRvalid", {15'b0, bus0.o_rvalid}, 16'd0);
        checkOutput("rdWrRdataHold", bus0.o_rdata, 16'hC0DE);
        doAccess(0, 1'b1, 1'b0, 16'hFF00, 16'h0000);
        checkOutput("rdGpio", bus0.o_rdata, 16'h1234);

        // Unmapped write sets the sticky error; STATUS reflects and clears it.
        doAccess(0, 1'b0, 1'b1, 16'hFF08, 16'h5555);
        checkOutput("unmappedErr", {15'b0, err0}, 16'd1);
        checkOutput("unmappedGpioKept", gpio0, 16'h1234);
        doAccess(0, 1'b1, 1'b0, 16'hFF04, 16'h0000);
        checkOutput("rdStatusSet", bus0.o_rdata, 16'h0001);
        doAccess(0, 1'b0, 1'b1, 16'hFF04, 16'h0000);
        checkOutput("wrStatusClears", {15'b0, err0}, 16'd0);
        doAccess(0, 1'b1, 1'b0, 16'hFF04, 16'h0000);
        checkOutput("rdStatusClear", bus0.o_rdata, 16'h0000);

        // First byte past RAM is unmapped: reads zero, flags error.
        doAccess(0, 1'b1, 1'b0, 16'h2000, 16'h0000);
        checkOutput("rdPastRamValid", {15'b0, bus0.o_rvalid}, 16'd1);
        checkOutput("rdPastRamData", bus0.o_rdata, 16'h0000);
        checkOutput("rdPastRamErr", {15'b0, err0}, 16'd1);
        doAccess(0, 1'b0, 1'b1, 16'hFF04, 16'h0000);
        checkOutput("errClearedAgain", {15'b0, err0}, 16'd0);

        // CYCLE register.
`ifdef CPU_MEM_CYCLE_COUNTER_EN
        doAccess(0, 1'b0, 1'b1, 16'hFF02, 16'hFFFF);
        repeat (9) stepCycle();
        doAccess(0, 1'b1, 1'b0, 16'hFF02, 16'h0000);
        checkOutput("rdCycle", bus0.o_rdata, 16'd9);
        checkOutput("rdCycleNoErr", {15'b0, err0}, 16'd0);
`else
        doAccess(0, 1'b1, 1'b0, 16'hFF02, 16'h0000);
        checkOutput("rdCycleAbsent", bus0.o_rdata, 16'h0000);
        checkOutput("rdCycleAbsentErr", {15'b0, err0}, 16'd1);
`endif

        // Three wait states: waitrequest high t..t+2, low at t+3, rvalid at t+4.
        doAccess(1, 1'b0, 1'b1, 16'h0020, 16'h5A5A);
        applyStimulus(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        @(negedge clock);
        checkOutput("wait3T0", {15'b0, bus3.o_waitrequest}, 16'd1);
        stepCycle();
        @(negedge clock);
        checkOutput("wait3T1", {15'b0, bus3.o_waitrequest}, 16'd1);
        stepCycle();
        @(negedge clock);
        checkOutput("wait3T2", {15'b0, bus3.o_waitrequest}, 16'd1);
        stepCycle();
        @(negedge clock);
        checkOutput("wait3T3", {15'b0, bus3.o_waitrequest}, 16'd0);
        checkOutput("wait3NoRvalidT3", {15'b0, bus3.o_rvalid}, 16'd0);
        stepCycle();
        applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("wait3RvalidT4", {15'b0, bus3.o_rvalid}, 16'd1);
        checkOutput("wait3Rdata", bus3.o_rdata, 16'h5A5A);
        stepCycle();
        checkOutput("wait3RvalidEnds", {15'b0, bus3.o_rvalid}, 16'd0);

        // Reset during S_WAIT aborts a write: old RAM word survives.
        doAccess(1, 1'b0, 1'b1, 16'h0040, 16'h1111);
        applyStimulus(1, 1'b0, 1'b1, 16'h0040, 16'hAAAA);
        repeat (2) stepCycle();
        resetN3 = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        stepCycle();
        resetN3 = 1'b1;
        stepCycle();
        doAccess(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        checkOutput("abortWrKeepsRam", bus3.o_rdata, 16'h1111);

        // Reset during S_WAIT aborts a read: no rvalid, rdata cleared.
        applyStimulus(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        repeat (2) stepCycle();
        resetN3 = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        stepCycle();
        checkOutput("abortRdNoRvalid", {15'b0, bus3.o_rvalid}, 16'd0);
        resetN3 = 1'b1;
        stepCycle();
        checkOutput("abortRdNoRvalidLater", {15'b0, bus3.o_rvalid}, 16'd0);
        checkOutput("abortRdRdataReset", bus3.o_rdata, 16'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
